// File: rtl/fan_speed_ctrl_pkg.sv
// fan_pkg: shared types and constants for the fan speed controller.
//   main_state_e : sequencer states (KICK, RUN, FAULT)
//   level_t      : 2-bit speed level, legal values 1..3
//   level_target : duty target for each level
package fan_pkg;
  localparam int TEMP_W = 8;
  localparam int DUTY_W = 10;
  localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

  typedef enum logic [1:0] {KICK, RUN, FAULT} main_state_e;
  typedef logic [1:0] level_t;

  // Level 0 never occurs; it falls into the level-1 target as a safe default.
  function automatic logic [DUTY_W-1:0] level_target(input level_t l);
    case (l)
      2'd2:    return 10'd512;
      2'd3:    return 10'd768;
      default: return 10'd256;
    endcase
  endfunction
endpackage

// File: rtl/fan_speed_ctrl_tach_monitor.sv
// tach_monitor: synchronises the raw tachometer, detects its rising edge and
// counts PWM periods without an edge while the controller is running.
//   CLK, nRST     clock, async active-low reset
//   tach          raw asynchronous tachometer input
//   period_start  PWM period wrap pulse
//   run           counter enabled (held at 0 otherwise)
//   stall         high while STALL_PERIODS periods elapsed without an edge
//   tach_edge     registered rising-edge pulse, 3 cycles after the tach rise
module tach_monitor #(
  parameter int STALL_PERIODS = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic tach,
  input  logic period_start,
  input  logic run,
  output logic stall,
  output logic tach_edge
);
  localparam int CW = $clog2(STALL_PERIODS + 1);
  localparam logic [CW-1:0] LIM = CW'(STALL_PERIODS);

  logic s1, s2, s3;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; tach_edge <= 1'b0;
    end else begin
      s1 <= tach;
      s2 <= s1;
      s3 <= s2;
      tach_edge <= s2 & ~s3;
    end
  end

  // An edge clears the count even when a period_start lands on the same cycle.
  // Saturates so the stall level holds until the sequencer reacts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          cnt <= '0;
    else if (!run || tach_edge)         cnt <= '0;
    else if (period_start && cnt != LIM) cnt <= cnt + 1'b1;
  end

  assign stall = run & (cnt == LIM);
endmodule

// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: closed-loop fan sequencer between the temperature sample
// stream and the PWM generator. Level selection with hysteresis, spin-up kick
// at full duty, per-period duty ramp, and tach-based stall fault.
//   CLK, nRST     clock, async active-low reset
//   temp_valid    temp sample strobe
//   temp          temperature sample (deg C)
//   period_start  PWM period wrap pulse
//   tach          raw tachometer
//   fault_clr     leave FAULT (ignored elsewhere)
//   duty          registered PWM duty
//   fan_speed     registered level 1..3 (3 in FAULT)
//   fault         registered stall fault flag
//   busy          KICK, or RUN with duty not yet at target
module fan_speed_ctrl
  import fan_pkg::*;
#(
  parameter int T_LOW         = 50,
  parameter int T_HIGH        = 70,
  parameter int HYST          = 3,
  parameter int RAMP_STEP     = 16,
  parameter int KICK_PERIODS  = 8,
  parameter int STALL_PERIODS = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              period_start,
  input  logic              tach,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] duty,
  output level_t            fan_speed,
  output logic              fault,
  output logic              busy
);
  localparam logic [TEMP_W-1:0] UP3 = TEMP_W'(T_HIGH);
  localparam logic [TEMP_W-1:0] UP2 = TEMP_W'(T_LOW);
  localparam logic [TEMP_W-1:0] DN1 = TEMP_W'(T_LOW - HYST);
  localparam logic [TEMP_W-1:0] DN2 = TEMP_W'(T_HIGH - HYST);
  localparam logic [DUTY_W:0]   STEP = (DUTY_W+1)'(RAMP_STEP);
  localparam int KW = $clog2(KICK_PERIODS + 1);
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS - 1);

  main_state_e state, state_nxt;
  level_t level, level_nxt;
  logic [DUTY_W-1:0] duty_nxt, target, ramp;
  logic [DUTY_W:0] d_ext, t_ext, diff, r_ext;
  logic [KW-1:0] kick_cnt, kick_nxt;
  logic stall;

  tach_monitor #(.STALL_PERIODS(STALL_PERIODS)) u_tach (
    .CLK(CLK), .nRST(nRST), .tach(tach), .period_start(period_start),
    .run(state == RUN), .stall(stall), .tach_edge()
  );

  // Level tracking runs in every state, including FAULT.
  always_comb begin
    level_nxt = level;
    if (temp_valid) begin
      case (level)
        2'd1:    if (temp > UP3) level_nxt = 2'd3;
                 else if (temp >= UP2) level_nxt = 2'd2;
        2'd2:    if (temp > UP3) level_nxt = 2'd3;
                 else if (temp < DN1) level_nxt = 2'd1;
        default: if (temp < DN1) level_nxt = 2'd1;
                 else if (temp <= DN2) level_nxt = 2'd2;
      endcase
    end
  end

  // Ramp toward the target of the already-registered level; one extra bit
  // keeps the subtraction/addition from wrapping near 0 or DUTY_MAX.
  assign target = level_target(level);
  always_comb begin
    d_ext = {1'b0, duty};
    t_ext = {1'b0, target};
    diff  = (d_ext >= t_ext) ? d_ext - t_ext : t_ext - d_ext;
    r_ext = (d_ext > t_ext) ? d_ext - STEP : d_ext + STEP;
    ramp  = (diff <= STEP) ? target : r_ext[DUTY_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    kick_nxt  = kick_cnt;
    case (state)
      KICK: begin
        duty_nxt = DUTY_MAX;
        if (period_start) begin
          if (kick_cnt == KICK_LAST) begin
            state_nxt = RUN;
            kick_nxt  = '0;
          end else begin
            kick_nxt = kick_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (stall) begin
          state_nxt = FAULT;
          duty_nxt  = DUTY_MAX;
        end else if (period_start) begin
          duty_nxt = ramp;
        end
      end
      FAULT: begin
        duty_nxt = DUTY_MAX;
        if (fault_clr) begin
          state_nxt = KICK;
          kick_nxt  = '0;
        end
      end
      default: state_nxt = KICK;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= KICK;
      duty      <= DUTY_MAX;
      kick_cnt  <= '0;
      level     <= 2'd1;
      fan_speed <= 2'd1;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      duty      <= duty_nxt;
      kick_cnt  <= kick_nxt;
      level     <= level_nxt;
      fan_speed <= (state_nxt == FAULT) ? 2'd3 : level_nxt;
      fault     <= (state_nxt == FAULT);
    end
  end

  assign busy = (state == KICK) | ((state == RUN) & (duty != target));
endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Bench for fan_speed_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the sequencer.
module tb_fan_speed_ctrl;
  logic CLK = 1'b0;
  logic nRST, temp_valid, period_start, tach, fault_clr;
  logic [7:0] temp;
  logic [9:0] duty;
  logic [1:0] fan_speed;
  logic fault, busy;
  int checks = 0, errors = 0;

  // model: state 0=KICK 1=RUN 2=FAULT
  int m_state, m_level, m_duty, m_kick, m_stall;
  bit th[4];

  always #5 CLK = ~CLK;

  fan_speed_ctrl dut (
    .CLK(CLK), .nRST(nRST), .temp_valid(temp_valid), .temp(temp),
    .period_start(period_start), .tach(tach), .fault_clr(fault_clr),
    .duty(duty), .fan_speed(fan_speed), .fault(fault), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int next_level(input int l, input int t);
    if (l == 1) return (t > 70) ? 3 : (t >= 50) ? 2 : 1;
    if (l == 2) return (t > 70) ? 3 : (t < 47) ? 1 : 2;
    return (t < 47) ? 1 : (t <= 67) ? 2 : 3;
  endfunction

  function automatic int toward(input int d, input int tg);
    if (d - tg <= 16 && tg - d <= 16) return tg;
    return (d > tg) ? d - 16 : d + 16;
  endfunction

  task automatic mreset();
    m_state = 0; m_level = 1; m_duty = 1023; m_kick = 0; m_stall = 0;
    for (int i = 0; i < 4; i++) th[i] = 1'b0;
  endtask

  // One clock of the reference behaviour. A tach rise sampled at cycle n
  // reaches the stall counter at cycle n+3.
  task automatic mstep(input bit tv, input int t, input bit ps, input bit fc, input bit tk);
    int old_lvl;
    bit te;
    old_lvl = m_level;
    te = th[2] & ~th[3];
    th[3] = th[2]; th[2] = th[1]; th[1] = th[0]; th[0] = tk;
    if (tv) m_level = next_level(m_level, t);
    case (m_state)
      0: begin
        m_stall = 0;
        if (ps) begin
          m_kick++;
          if (m_kick == 8) begin m_state = 1; m_kick = 0; end
        end
      end
      1: begin
        if (m_stall >= 64) begin
          m_state = 2; m_duty = 1023; m_stall = 0;
        end else begin
          if (ps) m_duty = toward(m_duty, 256 * old_lvl);
          if (te) m_stall = 0;
          else if (ps) m_stall++;
        end
      end
      default: if (fc) begin m_state = 0; m_kick = 0; m_stall = 0; end
    endcase
  endtask

  task automatic step(input bit tv, input int t, input bit ps, input bit fc);
    temp_valid = tv; temp = 8'(t); period_start = ps; fault_clr = fc;
    @(posedge CLK);
    mstep(tv, t, ps, fc, tach);
    #1;
    temp_valid = 1'b0; period_start = 1'b0; fault_clr = 1'b0;
    chk("duty", 32'(duty), 32'(m_duty));
    chk("fan_speed", 32'(fan_speed), 32'((m_state == 2) ? 3 : m_level));
    chk("fault", 32'(fault), 32'(m_state == 2));
    chk("busy", 32'(busy), 32'(m_state == 0 || (m_state == 1 && m_duty != 256 * m_level)));
  endtask

  // n PWM periods of 2..4 cycles; optional tach toggle and random temp samples.
  task automatic period(input int n, input bit toggle, input bit rnd);
    repeat (n) begin
      if (toggle) tach = ~tach;
      step(1'b0, 0, 1'b1, 1'b0);
      repeat ($urandom_range(1, 3)) begin
        if (rnd && $urandom_range(0, 3) == 0) step(1'b1, $urandom_range(30, 90), 1'b0, 1'b0);
        else step(1'b0, 0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    nRST = 1'b0; tach = 1'b0; temp_valid = 1'b0; temp = '0;
    period_start = 1'b0; fault_clr = 1'b0;
    mreset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_duty", 32'(duty), 32'd1023);
    chk("rst_fan_speed", 32'(fan_speed), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    nRST = 1'b1;

    // kick then ramp down to level-1 target
    period(7, 1'b1, 1'b0);
    chk("kick_duty", 32'(duty), 32'd1023);
    period(1, 1'b1, 1'b0);
    chk("run_entry_duty", 32'(duty), 32'd1023);
    period(1, 1'b1, 1'b0);
    chk("ramp_first", 32'(duty), 32'd1007);
    period(60, 1'b1, 1'b0);
    chk("ramp_floor", 32'(duty), 32'd256);
    chk("idle_busy", 32'(busy), 32'd0);

    // level up and ramp up
    step(1'b1, 60, 1'b0, 1'b0);
    chk("lvl2", 32'(fan_speed), 32'd2);
    period(1, 1'b1, 1'b0);
    chk("ramp_up", 32'(duty), 32'd272);
    step(1'b1, 75, 1'b0, 1'b0);
    chk("lvl3", 32'(fan_speed), 32'd3);
    period(40, 1'b1, 1'b0);
    chk("ramp_ceiling", 32'(duty), 32'd768);

    // hysteresis boundaries
    step(1'b1, 68, 1'b0, 1'b0); chk("hyst_68", 32'(fan_speed), 32'd3);
    step(1'b1, 67, 1'b0, 1'b0); chk("hyst_67", 32'(fan_speed), 32'd2);
    step(1'b1, 48, 1'b0, 1'b0); chk("hyst_48", 32'(fan_speed), 32'd2);
    step(1'b1, 46, 1'b0, 1'b0); chk("hyst_46", 32'(fan_speed), 32'd1);
    period(40, 1'b1, 1'b0);
    chk("back_to_256", 32'(duty), 32'd256);

    // temp_valid coincident with period_start uses the old level
    tach = ~tach;
    step(1'b1, 80, 1'b1, 1'b0);
    chk("coincident_hold", 32'(duty), 32'd256);
    period(1, 1'b1, 1'b0);
    chk("coincident_next", 32'(duty), 32'd272);
    period(8, 1'b1, 1'b0);
    chk("mid_ramp", 32'(duty), 32'd400);

    // async reset mid-ramp
    #2 nRST = 1'b0;
    #1;
    chk("arst_duty", 32'(duty), 32'd1023);
    chk("arst_fan_speed", 32'(fan_speed), 32'd1);
    chk("arst_fault", 32'(fault), 32'd0);
    mreset();
    @(negedge CLK) nRST = 1'b1;

    // stall fault and clear
    period(8, 1'b1, 1'b0);
    period(10, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("clr_ignored", 32'(fault), 32'd0);
    period(66, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("stall_fault", 32'(fault), 32'd1);
    chk("stall_duty", 32'(duty), 32'd1023);
    chk("stall_speed", 32'(fan_speed), 32'd3);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);

    // randomized traffic, including a stuck stretch and random clears
    for (int i = 0; i < 150; i++) begin
      period(1, $urandom_range(0, 3) != 0, 1'b1);
      if ($urandom_range(0, 15) == 0) step(1'b0, 0, 1'b0, 1'b1);
    end
    period(70, 1'b0, 1'b1);
    for (int i = 0; i < 120; i++) begin
      period(1, $urandom_range(0, 2) != 0, 1'b1);
      if ($urandom_range(0, 7) == 0) step(1'b1, $urandom_range(30, 90), 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
